// File: rtl/affine_sb_scheduler_pkg.sv
// Shared types, field widths and helpers for the affine subblock scheduler.
// Imported by the interface, the raster counter and the scheduler top.
package affine_sb_scheduler_pkg;

  localparam int COORD_W          = 8;
  localparam int SBCNT_W          = 4;
  localparam int CPMV_W           = 16;
  localparam int INDEX_W          = 8;
  localparam int WDOG_W           = 16;
  localparam int SB_SIZE_LOG2_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_BLANK  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FINISH = 3'd5
  } sched_state_e;

  // Sample coordinate of subblock idx along one axis; wraps modulo 256.
  function automatic logic [COORD_W-1:0] sb_coord(input logic [COORD_W-1:0] base,
                                                  input logic [SBCNT_W-1:0] idx,
                                                  input int unsigned        log2);
    logic [COORD_W-1:0] off;
    off = COORD_W'(idx) << log2;
    return base + off;
  endfunction

endpackage

// File: rtl/affine_sb_scheduler_if.sv
// Job handshake plus subblock control bus between the scheduler and its environment.
// master = job issuer / MV-generator top level, slave = scheduler.
interface affine_sb_scheduler_if;
  import affine_sb_scheduler_pkg::*;

  logic                CU_VALID;
  logic                CU_READY;
  logic [COORD_W-1:0]  CU_X;
  logic [COORD_W-1:0]  CU_Y;
  logic [SBCNT_W-1:0]  CU_W_SB;
  logic [SBCNT_W-1:0]  CU_H_SB;
  logic [CPMV_W-1:0]   CU_CPMV_0;
  logic [CPMV_W-1:0]   CU_CPMV_1;
  logic                ABORT;
  logic                SB_START;
  logic [COORD_W-1:0]  SB_COORD_X;
  logic [COORD_W-1:0]  SB_COORD_Y;
  logic [CPMV_W-1:0]   SB_CPMV_0;
  logic [CPMV_W-1:0]   SB_CPMV_1;
  logic                SB_DONE;
  logic [INDEX_W-1:0]  SB_INDEX;
  logic                CU_DONE;
  logic                BUSY;
  logic                ERR_TIMEOUT;

  modport master (
    output CU_VALID, CU_X, CU_Y, CU_W_SB, CU_H_SB, CU_CPMV_0, CU_CPMV_1, ABORT, SB_DONE,
    input  CU_READY, SB_START, SB_COORD_X, SB_COORD_Y, SB_CPMV_0, SB_CPMV_1,
           SB_INDEX, CU_DONE, BUSY, ERR_TIMEOUT
  );

  modport slave (
    input  CU_VALID, CU_X, CU_Y, CU_W_SB, CU_H_SB, CU_CPMV_0, CU_CPMV_1, ABORT, SB_DONE,
    output CU_READY, SB_START, SB_COORD_X, SB_COORD_Y, SB_CPMV_0, SB_CPMV_1,
           SB_INDEX, CU_DONE, BUSY, ERR_TIMEOUT
  );

endinterface

// File: rtl/affine_sb_scheduler_sb_raster_counter.sv
// Raster-order subblock position and linear index within the current CU.
// last flags the bottom-right subblock.
module sb_raster_counter
  import affine_sb_scheduler_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET_ALL_N,
  input  logic               clear,
  input  logic               step,
  input  logic [SBCNT_W-1:0] w,
  input  logic [SBCNT_W-1:0] h,
  output logic [SBCNT_W-1:0] sb_x,
  output logic [SBCNT_W-1:0] sb_y,
  output logic [INDEX_W-1:0] sb_index,
  output logic               last
);

  logic [SBCNT_W-1:0] sb_x_r;
  logic [SBCNT_W-1:0] sb_y_r;
  logic [INDEX_W-1:0] sb_index_r;

  // Position update: clear on job accept, advance one raster step on request.
  always_ff @(posedge CLK) begin
    if (!RESET_ALL_N) begin
      sb_x_r     <= {SBCNT_W{1'b0}};
      sb_y_r     <= {SBCNT_W{1'b0}};
      sb_index_r <= {INDEX_W{1'b0}};
    end else if (clear) begin
      sb_x_r     <= {SBCNT_W{1'b0}};
      sb_y_r     <= {SBCNT_W{1'b0}};
      sb_index_r <= {INDEX_W{1'b0}};
    end else if (step) begin
      if (sb_x_r < w) begin
        sb_x_r <= sb_x_r + 4'd1;
      end else begin
        sb_x_r <= {SBCNT_W{1'b0}};
        sb_y_r <= sb_y_r + 4'd1;
      end
      sb_index_r <= sb_index_r + 8'd1;
    end else begin
      sb_x_r     <= sb_x_r;
      sb_y_r     <= sb_y_r;
      sb_index_r <= sb_index_r;
    end
  end

  assign sb_x     = sb_x_r;
  assign sb_y     = sb_y_r;
  assign sb_index = sb_index_r;
  assign last     = (sb_x_r == w) && (sb_y_r == h);

endmodule

// File: rtl/affine_sb_scheduler.sv
// Walks one affine CU through the MV-generator top level one subblock at a time,
// with a per-subblock watchdog, abort, and a single completion pulse per CU.
module affine_sb_scheduler
  import affine_sb_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned SB_SIZE_LOG2   = SB_SIZE_LOG2_DEF
) (
  input logic                  CLK,
  input logic                  RESET_ALL_N,
  affine_sb_scheduler_if.slave bus
);

  localparam bit                WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  sched_state_e       state_r;
  sched_state_e       raw_next_s;
  sched_state_e       next_state_s;
  logic               accept_s;
  logic               abort_s;
  logic               raw_step_s;
  logic               step_s;
  logic               raw_timeout_s;
  logic               timeout_s;
  logic [WDOG_W-1:0]  wdog_r;

  logic [COORD_W-1:0] cu_x_r;
  logic [COORD_W-1:0] cu_y_r;
  logic [SBCNT_W-1:0] w_r;
  logic [SBCNT_W-1:0] h_r;

  logic               cu_ready_r;
  logic               sb_start_r;
  logic               cu_done_r;
  logic               busy_r;
  logic               err_timeout_r;
  logic [COORD_W-1:0] sb_coord_x_r;
  logic [COORD_W-1:0] sb_coord_y_r;
  logic [CPMV_W-1:0]  sb_cpmv_0_r;
  logic [CPMV_W-1:0]  sb_cpmv_1_r;

  logic [SBCNT_W-1:0] sb_x_s;
  logic [SBCNT_W-1:0] sb_y_s;
  logic [INDEX_W-1:0] sb_index_s;
  logic               last_s;

  sb_raster_counter u_raster (
    .CLK         (CLK),
    .RESET_ALL_N (RESET_ALL_N),
    .clear       (accept_s),
    .step        (step_s),
    .w           (w_r),
    .h           (h_r),
    .sb_x        (sb_x_s),
    .sb_y        (sb_y_s),
    .sb_index    (sb_index_s),
    .last        (last_s)
  );

  // Next-state decode; ABORT overrides every non-IDLE transition.
  always_comb begin
    raw_next_s    = state_r;
    accept_s      = 1'b0;
    raw_step_s    = 1'b0;
    raw_timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.CU_VALID) begin
          accept_s   = 1'b1;
          raw_next_s = ST_LAUNCH;
        end else begin
          raw_next_s = ST_IDLE;
        end
      end
      ST_LAUNCH: raw_next_s = ST_BLANK;
      ST_BLANK:  raw_next_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.SB_DONE) begin
          raw_next_s = ST_NEXT;
        end else if (WDOG_EN && (wdog_r == WDOG_LAST)) begin
          raw_timeout_s = 1'b1;
          raw_next_s    = ST_IDLE;
        end else begin
          raw_next_s = ST_WAIT;
        end
      end
      ST_NEXT: begin
        if (last_s) begin
          raw_next_s = ST_FINISH;
        end else begin
          raw_step_s = 1'b1;
          raw_next_s = ST_LAUNCH;
        end
      end
      ST_FINISH: raw_next_s = ST_IDLE;
      default:   raw_next_s = ST_IDLE;
    endcase
    abort_s      = (state_r != ST_IDLE) && bus.ABORT;
    next_state_s = abort_s ? ST_IDLE : raw_next_s;
    step_s       = raw_step_s & ~abort_s;
    timeout_s    = raw_timeout_s & ~abort_s;
  end

  // State, Moore outputs registered from the next state, job fields and watchdog.
  always_ff @(posedge CLK) begin
    if (!RESET_ALL_N) begin
      state_r       <= ST_IDLE;
      cu_ready_r    <= 1'b1;
      sb_start_r    <= 1'b0;
      cu_done_r     <= 1'b0;
      busy_r        <= 1'b0;
      err_timeout_r <= 1'b0;
      wdog_r        <= {WDOG_W{1'b0}};
      cu_x_r        <= {COORD_W{1'b0}};
      cu_y_r        <= {COORD_W{1'b0}};
      w_r           <= {SBCNT_W{1'b0}};
      h_r           <= {SBCNT_W{1'b0}};
      sb_coord_x_r  <= {COORD_W{1'b0}};
      sb_coord_y_r  <= {COORD_W{1'b0}};
      sb_cpmv_0_r   <= {CPMV_W{1'b0}};
      sb_cpmv_1_r   <= {CPMV_W{1'b0}};
    end else begin
      state_r    <= next_state_s;
      cu_ready_r <= (next_state_s == ST_IDLE);
      busy_r     <= (next_state_s != ST_IDLE);
      sb_start_r <= (next_state_s == ST_LAUNCH);
      cu_done_r  <= (next_state_s == ST_FINISH);

      if (accept_s) begin
        cu_x_r        <= bus.CU_X;
        cu_y_r        <= bus.CU_Y;
        w_r           <= bus.CU_W_SB;
        h_r           <= bus.CU_H_SB;
        sb_cpmv_0_r   <= bus.CU_CPMV_0;
        sb_cpmv_1_r   <= bus.CU_CPMV_1;
        sb_coord_x_r  <= bus.CU_X;
        sb_coord_y_r  <= bus.CU_Y;
        err_timeout_r <= 1'b0;
      end else if (step_s) begin
        // Coordinates track the position the raster counter moves to on this edge.
        if (sb_x_s < w_r) begin
          sb_coord_x_r <= sb_coord(cu_x_r, sb_x_s + 4'd1, SB_SIZE_LOG2);
        end else begin
          sb_coord_x_r <= cu_x_r;
          sb_coord_y_r <= sb_coord(cu_y_r, sb_y_s + 4'd1, SB_SIZE_LOG2);
        end
      end else if (timeout_s) begin
        err_timeout_r <= 1'b1;
      end else begin
        err_timeout_r <= err_timeout_r;
      end

      if (state_r == ST_BLANK) begin
        wdog_r <= {WDOG_W{1'b0}};
      end else if ((state_r == ST_WAIT) && !bus.SB_DONE && !raw_timeout_s) begin
        wdog_r <= wdog_r + 16'd1;
      end else begin
        wdog_r <= wdog_r;
      end
    end
  end

  assign bus.CU_READY    = cu_ready_r;
  assign bus.SB_START    = sb_start_r;
  assign bus.CU_DONE     = cu_done_r;
  assign bus.BUSY        = busy_r;
  assign bus.ERR_TIMEOUT = err_timeout_r;
  assign bus.SB_COORD_X  = sb_coord_x_r;
  assign bus.SB_COORD_Y  = sb_coord_y_r;
  assign bus.SB_CPMV_0   = sb_cpmv_0_r;
  assign bus.SB_CPMV_1   = sb_cpmv_1_r;
  assign bus.SB_INDEX    = sb_index_s;

endmodule
